// File: rtl/npu_pkg.sv
// Shared NPU definitions: default geometry/width constants, the output-width
// helper and the layer sequencer state type.
package npu_pkg;

  localparam int unsigned IMG_W_DEFAULT           = 28;
  localparam int unsigned KERNEL_SIZE_DEFAULT     = 3;
  localparam int unsigned DATA_WIDTH_DEFAULT      = 8;
  localparam int unsigned BRAM_ADDR_WIDTH_DEFAULT = 10;
  localparam int unsigned KSIZE_WIDTH_DEFAULT     = 7;

  // Number of valid (unpadded) output positions along one edge.
  function automatic int unsigned out_w(input int unsigned img_w, input int unsigned k);
    return img_w - k + 1;
  endfunction

  localparam int unsigned OUT_W_DEFAULT = out_w(IMG_W_DEFAULT, KERNEL_SIZE_DEFAULT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOAD_WAIT,
    ST_CONV,
    ST_CONV_WAIT,
    ST_WRITE,
    ST_DONE
  } npu_state_e;

endpackage

// File: rtl/npu_layer_ctrl_if.sv
// Handshake/bus bundle between the layer sequencer (master) and the NPU top,
// kernel loader, convolution engine and output BRAM (slave).
interface npu_layer_ctrl_if
  import npu_pkg::*;
#(
  parameter int unsigned BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DEFAULT,
  parameter int unsigned KSIZE_WIDTH     = KSIZE_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEFAULT
);
  logic                       i_start;
  logic [BRAM_ADDR_WIDTH-1:0] i_kernal_start_addr;
  logic [KSIZE_WIDTH-1:0]     i_kernal_element_size;
  logic                       o_load_start;
  logic [BRAM_ADDR_WIDTH-1:0] o_load_addr;
  logic [KSIZE_WIDTH-1:0]     o_load_size;
  logic                       i_load_done;
  logic                       o_conv_start;
  logic [BRAM_ADDR_WIDTH-1:0] o_win_row;
  logic [BRAM_ADDR_WIDTH-1:0] o_win_col;
  logic                       i_conv_done;
  logic [DATA_WIDTH-1:0]      i_conv_result;
  logic                       o_out_wr_en;
  logic [BRAM_ADDR_WIDTH-1:0] o_out_wr_addr;
  logic [DATA_WIDTH-1:0]      o_out_wr_data;
  logic                       o_busy;
  logic                       o_done;

  modport master (
    input  i_start, i_kernal_start_addr, i_kernal_element_size,
           i_load_done, i_conv_done, i_conv_result,
    output o_load_start, o_load_addr, o_load_size, o_conv_start,
           o_win_row, o_win_col, o_out_wr_en, o_out_wr_addr,
           o_out_wr_data, o_busy, o_done
  );

  modport slave (
    output i_start, i_kernal_start_addr, i_kernal_element_size,
           i_load_done, i_conv_done, i_conv_result,
    input  o_load_start, o_load_addr, o_load_size, o_conv_start,
           o_win_row, o_win_col, o_out_wr_en, o_out_wr_addr,
           o_out_wr_data, o_busy, o_done
  );
endinterface

// File: rtl/npu_window_counter.sv
// Raster-order row/col counter over the OUT_W x OUT_W output grid, with
// last-position flag and linear output address row*OUT_W+col.
module npu_window_counter
  import npu_pkg::*;
#(
  parameter int unsigned OUT_W  = OUT_W_DEFAULT,
  parameter int unsigned ADDR_W = BRAM_ADDR_WIDTH_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_row,
  output logic [ADDR_W-1:0] o_col,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUT_W - 1);

  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;

  assign o_row  = row_q;
  assign o_col  = col_q;
  assign o_last = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign o_addr = row_q * ADDR_W'(OUT_W) + col_q;

  always_comb begin
    // NOTE: hold-value defaults first so every path assigns row_d/col_d and no latch is inferred.
    row_d = row_q;
    col_d = col_q;
    if (i_clr || (i_adv && o_last)) begin
      row_d = '0;
      col_d = '0;
    end else if (i_adv) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = row_q + ADDR_W'(1);
      end else begin
        col_d = col_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking assignments for state so all flops update together on the edge.
    if (i_rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/npu_layer_ctrl.sv
// Convolution-layer sequencer: kernel load, then one engine run and one output
// write per output pixel. Optional NPU_LAYER_RELU_EN clamps negative results to 0.
module npu_layer_ctrl
  import npu_pkg::*;
#(
  parameter int unsigned IMG_W           = IMG_W_DEFAULT,
  parameter int unsigned KERNEL_SIZE     = KERNEL_SIZE_DEFAULT,
  parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEFAULT,
  parameter int unsigned BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DEFAULT,
  parameter int unsigned KSIZE_WIDTH     = KSIZE_WIDTH_DEFAULT
) (
  input logic              i_clk,
  input logic              i_rst,
  npu_layer_ctrl_if.master bus
);

  localparam int unsigned OUT_W = out_w(IMG_W, KERNEL_SIZE);

  npu_state_e                 state_q, state_d;
  logic                       load_start_q, load_start_d;
  logic [BRAM_ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
  logic [KSIZE_WIDTH-1:0]     load_size_q, load_size_d;
  logic                       conv_start_q, conv_start_d;
  logic [BRAM_ADDR_WIDTH-1:0] win_row_q, win_row_d;
  logic [BRAM_ADDR_WIDTH-1:0] win_col_q, win_col_d;
  logic                       wr_en_q, wr_en_d;
  logic [BRAM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]      wr_data_q, wr_data_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       cnt_clr, cnt_adv, cnt_last;
  logic [BRAM_ADDR_WIDTH-1:0] cnt_row, cnt_col, cnt_addr;
  logic [DATA_WIDTH-1:0]      result_gated;

  assign cnt_clr = (state_q == ST_IDLE) && bus.i_start;
  assign cnt_adv = (state_q == ST_WRITE);

  npu_window_counter #(
    .OUT_W  (OUT_W),
    .ADDR_W (BRAM_ADDR_WIDTH)
  ) u_win_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (cnt_clr),
    .i_adv  (cnt_adv),
    .o_row  (cnt_row),
    .o_col  (cnt_col),
    .o_addr (cnt_addr),
    .o_last (cnt_last)
  );

`ifdef NPU_LAYER_RELU_EN
  assign result_gated = bus.i_conv_result[DATA_WIDTH-1] ? '0 : bus.i_conv_result;
`else
  assign result_gated = bus.i_conv_result;
`endif

  always_comb begin
    state_d      = state_q;
    load_addr_d  = load_addr_q;
    load_size_d  = load_size_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    load_start_d = 1'b0;
    conv_start_d = 1'b0;
    wr_en_d      = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          load_addr_d = bus.i_kernal_start_addr;
          load_size_d = bus.i_kernal_element_size;
          busy_d      = 1'b1;
          state_d     = (bus.i_kernal_element_size == '0) ? ST_CONV : ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_start_d = 1'b1;
        state_d      = ST_LOAD_WAIT;
      end
      ST_LOAD_WAIT: begin
        if (bus.i_load_done) state_d = ST_CONV;
      end
      ST_CONV: begin
        conv_start_d = 1'b1;
        win_row_d    = cnt_row;
        win_col_d    = cnt_col;
        state_d      = ST_CONV_WAIT;
      end
      ST_CONV_WAIT: begin
        // The write strobe is set on capture so it follows i_conv_done by one cycle.
        if (bus.i_conv_done) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_addr;
          wr_data_d = result_gated;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (cnt_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      load_start_q <= 1'b0;
      load_addr_q  <= '0;
      load_size_q  <= '0;
      conv_start_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_start_q <= load_start_d;
      load_addr_q  <= load_addr_d;
      load_size_q  <= load_size_d;
      conv_start_q <= conv_start_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.o_load_start  = load_start_q;
  assign bus.o_load_addr   = load_addr_q;
  assign bus.o_load_size   = load_size_q;
  assign bus.o_conv_start  = conv_start_q;
  assign bus.o_win_row     = win_row_q;
  assign bus.o_win_col     = win_col_q;
  assign bus.o_out_wr_en   = wr_en_q;
  assign bus.o_out_wr_addr = wr_addr_q;
  assign bus.o_out_wr_data = wr_data_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;

endmodule

// File: doc/npu_layer_ctrl.md
Name: npu_layer_ctrl

Overview:
- Top-level sequencer for one convolution layer of the NPU.
- On i_start it runs kernel loading (BRAM -> kernel register file), then steps the convolution engine over every valid output position of the input image, writing each result to the output feature-map BRAM.
- It sits between the NPU top and the kernel loader / convolveX engines and owns their start/done handshakes.

Parameters:
- IMG_W, 28, input image width and height in pixels (square image).
- KERNEL_SIZE, 3, kernel edge length; output width OUT_W = IMG_W-KERNEL_SIZE+1.
- DATA_WIDTH, 8, width of convolution result and output write data.
- BRAM_ADDR_WIDTH, 10, width of the BRAM address buses.
- KSIZE_WIDTH, 7, width of the kernel element count.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  single-cycle layer start request
- i_kernal_start_addr  in  BRAM_ADDR_WIDTH  BRAM base address of kernel weights
- i_kernal_element_size  in  KSIZE_WIDTH  number of kernel weights to load
- o_load_start  out  1  one-cycle start pulse to the kernel loader
- o_load_addr  out  BRAM_ADDR_WIDTH  latched kernel base address
- o_load_size  out  KSIZE_WIDTH  latched kernel size
- i_load_done  in  1  kernel loader completion pulse
- o_conv_start  out  1  one-cycle start pulse to the convolution engine
- o_win_row  out  BRAM_ADDR_WIDTH  top-left row of the current window
- o_win_col  out  BRAM_ADDR_WIDTH  top-left column of the current window
- i_conv_done  in  1  convolution completion pulse
- i_conv_result  in  DATA_WIDTH  result, valid with i_conv_done
- o_out_wr_en  out  1  output BRAM write strobe
- o_out_wr_addr  out  BRAM_ADDR_WIDTH  row*OUT_W+col
- o_out_wr_data  out  DATA_WIDTH  value written
- o_busy  out  1  high from the cycle after accepted start until DONE
- o_done  out  1  one-cycle layer-complete pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; row and col counters 0. Reset is asynchronous and may arrive mid-operation. It aborts the layer with no o_done and no further writes.
- States: IDLE, LOAD, LOAD_WAIT, CONV, CONV_WAIT, WRITE, DONE.
- IDLE:
  - On i_start, latch addr and size into o_load_addr/o_load_size and clear counters.
  - Go to LOAD, or to CONV if size==0 (kernel load is skipped).
  - i_start is ignored in every other state.
- LOAD: assert o_load_start for exactly one cycle, then go to LOAD_WAIT.
- LOAD_WAIT: wait for i_load_done, then go to CONV. i_load_done is ignored in all other states.
- CONV:
  - o_conv_start is pulsed one cycle. o_win_row/o_win_col are driven from the counters and held stable until i_conv_done.
  - Next state is CONV_WAIT.
- CONV_WAIT: on i_conv_done, capture i_conv_result and go to WRITE. i_conv_done is ignored outside CONV_WAIT.
- WRITE:
  - Assert o_out_wr_en for one cycle with address row*OUT_W+col.
  - Advance col. On col==OUT_W-1, wrap col to 0 and increment row.
  - If row==OUT_W-1 and col==OUT_W-1, go to DONE; otherwise go to CONV.
- DONE: o_done=1 for one cycle, o_busy falls in the same cycle, then return to IDLE. A start arriving in the DONE cycle is ignored.
- Latency:
  - i_start to o_load_start: 2 cycles (IDLE->LOAD registered).
  - i_conv_done to o_out_wr_en: 1 cycle.
  - Minimum per-pixel overhead is 3 controller cycles plus engine latency.
- Address arithmetic is unsigned. It must not overflow BRAM_ADDR_WIDTH; 26*26=676 < 1024 at defaults.
- Pulses on o_load_start/o_conv_start never coincide with o_out_wr_en.

Optional Feature:
- Macro NPU_LAYER_RELU_EN.
  - Defined: i_conv_result is treated as signed two's complement. Negative values are written as 0; non-negative values pass unchanged.
  - Undefined: the result is written unmodified.

Decomposition:
- Shared package npu_pkg holds:
  - the state enum type;
  - the OUT_W helper constant;
  - the default IMG_W, KERNEL_SIZE and DATA_WIDTH constants shared with the loader and convolution engine.
- One natural sub-module: npu_window_counter, which holds the row/col counters, wrap logic, last-position flag and address multiply-add.

Test Plan:
- Reset → all outputs 0. start, addr=15, size=9 → o_load_start pulses 2 cycles later with o_load_addr=15, o_load_size=9. Responders return done after 4 cycles. Expect exactly 676 writes, addresses 0..675 in order, then a single o_done.
- size=0 → no o_load_start; first o_conv_start within 2 cycles of start; window (0,0).
- Window stepping → after the 26th write, o_win_row=1, o_win_col=0 and address 26 is next. The last write is at address 675 with window (25,25).
- i_start and a spurious i_load_done/i_conv_done pulsed mid-CONV → ignored: no state change, counters unchanged, no extra write.
- Reset asserted in CONV_WAIT at pixel 100 → outputs 0 immediately, no o_done. A following start runs a full layer from address 0.
- NPU_LAYER_RELU_EN defined, i_conv_result=8'hF0 → write data 0; 8'h12 → 8'h12. Without the macro, 8'hF0 is written as 8'hF0.
